mem_access: RTL and testbench

Memory-stage access unit sitting directly downstream of the EX/MEM pipeline register, consuming its control and data fields and driving the external data-memory bus. It turns MRead/MWrite into a request/acknowledge transaction, stalls the front of the pipeline while the access is outstanding, and registers results into the MEM/WB fields. Misaligned addresses and bus timeouts are reported, and the faulting instruction is retired without a register write.

---
 rtl/mem_access.sv | 167 ++++++++++++++++
 tb/tb_mem_access.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Purpose  : Memory-stage access unit placed after the EX/MEM register.
//            Converts MRead/MWrite into a req/ack bus transaction, stalls the
//            front of the pipeline while the access is outstanding, and
//            registers the MEM/WB fields. Misaligned accesses and bus
//            timeouts are flagged, and the instruction retires with its
//            register write cancelled.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT      max BUSY cycles without mem_ack before abort (>= 2)
// Ports
//   clock        rising-edge clock
//   rst          synchronous reset, active low
//   MRead/MWrite load / store request (store wins if both set)
//   WB, RegWrite write-back select and register-write enable
//   ALUIn        ALU result / byte address
//   WriteData    store data
//   RegRD        destination register
//   mem_req/mem_we/mem_addr/mem_wdata  registered bus request
//   mem_rdata/mem_ack                  bus response (ack is one cycle)
//   stall        combinational hold for PC/IF/ID/EX/MEM
//   bus_err      one-cycle pulse: access aborted on timeout
//   misalign_err one-cycle pulse: misaligned access rejected
//   WBreg, RegWritereg, ReadDataReg, ALUreg, RegRDreg  MEM/WB fields
// ============================================================================
module mem_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        MRead,
  input  logic        MWrite,
  input  logic        WB,
  input  logic        RegWrite,
  input  logic [31:0] ALUIn,
  input  logic [31:0] WriteData,
  input  logic [4:0]  RegRD,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        bus_err,
  output logic        misalign_err,
  output logic        WBreg,
  output logic        RegWritereg,
  output logic [31:0] ReadDataReg,
  output logic [31:0] ALUreg,
  output logic [4:0]  RegRDreg
);

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic access;
  logic aligned;
  logic at_limit;

  assign access   = MRead | MWrite;
  assign aligned  = (ALUIn[1:0] == 2'b00);
  assign at_limit = (cnt == CNT_LAST);

  // Stall drops in the BUSY cycle that completes (ack) or gives up (last
  // count), so EX/MEM advances on the same edge that retires the access.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = access & aligned;
      BUSY:    stall = ~mem_ack & ~at_limit;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      bus_err      <= 1'b0;
      misalign_err <= 1'b0;
      WBreg        <= 1'b0;
      RegWritereg  <= 1'b0;
      ReadDataReg  <= '0;
      ALUreg       <= '0;
      RegRDreg     <= '0;
    end else begin
      // Error flags are pulses; only the branches below raise them.
      bus_err      <= 1'b0;
      misalign_err <= 1'b0;

      case (state)
        IDLE: begin
          if (access && aligned) begin
            state       <= BUSY;
            cnt         <= '0;
            mem_req     <= 1'b1;
            mem_we      <= MWrite;
            mem_addr    <= ALUIn;
            mem_wdata   <= WriteData;
            WBreg       <= 1'b0;
            RegWritereg <= 1'b0;
          end else if (access) begin
            // Misaligned: retire the instruction with its write cancelled.
            misalign_err <= 1'b1;
            WBreg        <= 1'b0;
            RegWritereg  <= 1'b0;
            ALUreg       <= ALUIn;
            RegRDreg     <= RegRD;
          end else begin
            WBreg       <= WB;
            RegWritereg <= RegWrite;
            ALUreg      <= ALUIn;
            RegRDreg    <= RegRD;
          end
        end

        BUSY: begin
          // EX/MEM is frozen by stall, so its fields still describe the
          // instruction that owns this transaction.
          if (mem_ack) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            WBreg       <= WB;
            RegWritereg <= RegWrite;
            ALUreg      <= ALUIn;
            RegRDreg    <= RegRD;
            if (!mem_we) begin
              ReadDataReg <= mem_rdata;
            end
          end else if (at_limit) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            bus_err     <= 1'b1;
            WBreg       <= 1'b0;
            RegWritereg <= 1'b0;
            ALUreg      <= ALUIn;
            RegRDreg    <= RegRD;
          end else begin
            cnt         <= cnt + 1'b1;
            WBreg       <= 1'b0;
            RegWritereg <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access
// Purpose  : Self-checking bench for mem_access. Instructions are issued one
//            at a time; for each one the bench knows the memory latency it
//            will grant and derives the expected cycle-by-cycle outputs from
//            the instruction's timeline. A negedge process compares every
//            cycle; directed scenarios add literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_access;

  localparam int T = 4;

  logic        clock = 1'b0;
  logic        rst;
  logic        MRead, MWrite, WB, RegWrite;
  logic [31:0] ALUIn, WriteData;
  logic [4:0]  RegRD;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall, bus_err, misalign_err;
  logic        WBreg, RegWritereg;
  logic [31:0] ReadDataReg, ALUreg;
  logic [4:0]  RegRDreg;

  mem_access #(.TIMEOUT(T)) dut (
    .clock(clock), .rst(rst),
    .MRead(MRead), .MWrite(MWrite), .WB(WB), .RegWrite(RegWrite),
    .ALUIn(ALUIn), .WriteData(WriteData), .RegRD(RegRD),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .bus_err(bus_err), .misalign_err(misalign_err),
    .WBreg(WBreg), .RegWritereg(RegWritereg), .ReadDataReg(ReadDataReg),
    .ALUreg(ALUreg), .RegRDreg(RegRDreg)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Expected outputs for the current cycle
  bit          exp_req, exp_we, exp_stall, exp_bus_err, exp_mis, exp_wb, exp_rw;
  logic [31:0] exp_addr, exp_wdata, exp_rdata, exp_alu;
  logic [4:0]  exp_rd;

  bit chk_on       = 1'b0;
  bit chk_stall_on = 1'b1;
  int stall_hi     = 0;
  int req_hi       = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_on) begin
      chk("mem_req", mem_req, exp_req);
      if (exp_req) begin
        chk("mem_we", mem_we, exp_we);
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wdata", mem_wdata, exp_wdata);
      end
      if (chk_stall_on) chk("stall", stall, exp_stall);
      chk("bus_err", bus_err, exp_bus_err);
      chk("misalign_err", misalign_err, exp_mis);
      chk("WBreg", WBreg, exp_wb);
      chk("RegWritereg", RegWritereg, exp_rw);
      chk("ReadDataReg", ReadDataReg, exp_rdata);
      chk("ALUreg", ALUreg, exp_alu);
      chk("RegRDreg", RegRDreg, exp_rd);
      if (stall)   stall_hi++;
      if (mem_req) req_hi++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    exp_bus_err = 1'b0;
    exp_mis     = 1'b0;
  endtask

  task automatic zero_expect();
    exp_req = 0; exp_we = 0; exp_addr = 0; exp_wdata = 0; exp_stall = 0;
    exp_bus_err = 0; exp_mis = 0; exp_wb = 0; exp_rw = 0;
    exp_rdata = 0; exp_alu = 0; exp_rd = 0;
  endtask

  // Issue one instruction. delay = BUSY-cycle index of the ack (>= T means
  // no ack, i.e. timeout). abort_at = BUSY-cycle index at which reset is
  // applied together with an ack (-1 = never). spur = ack while IDLE.
  task automatic exec(input bit rd_i, input bit wr_i, input bit wb_i, input bit rw_i,
                      input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                      input int delay, input logic [31:0] rdata, input bit spur,
                      input int abort_at);
    bit acc, al;
    acc = rd_i | wr_i;
    al  = (alu[1:0] == 2'b00);
    MRead = rd_i; MWrite = wr_i; WB = wb_i; RegWrite = rw_i;
    ALUIn = alu; WriteData = wd; RegRD = rd;
    mem_ack = spur; mem_rdata = $urandom;
    exp_stall = acc && al;
    tick();
    mem_ack = 1'b0;
    if (!acc) begin
      exp_wb = wb_i; exp_rw = rw_i; exp_alu = alu; exp_rd = rd;
    end else if (!al) begin
      exp_mis = 1'b1; exp_wb = 0; exp_rw = 0; exp_alu = alu; exp_rd = rd;
    end else begin
      exp_req = 1'b1; exp_we = wr_i; exp_addr = alu; exp_wdata = wd;
      exp_wb = 0; exp_rw = 0;
      for (int k = 0; k < T; k++) begin
        if (k == abort_at) begin
          rst = 1'b0; mem_ack = 1'b1; chk_stall_on = 1'b0;
          tick();
          rst = 1'b1; mem_ack = 1'b0; chk_stall_on = 1'b1;
          MRead = 0; MWrite = 0; WB = 0; RegWrite = 0;
          zero_expect();
          return;
        end
        mem_ack   = (k == delay);
        mem_rdata = (k == delay) ? rdata : $urandom;
        exp_stall = (k != delay) && (k != T - 1);
        tick();
        mem_ack = 1'b0;
        if (k == delay) begin
          exp_req = 0; exp_wb = wb_i; exp_rw = rw_i; exp_alu = alu; exp_rd = rd;
          if (!wr_i) exp_rdata = rdata;
          break;
        end else if (k == T - 1) begin
          exp_req = 0; exp_bus_err = 1'b1; exp_wb = 0; exp_rw = 0;
          exp_alu = alu; exp_rd = rd;
        end
      end
    end
    // Park the inputs so a leftover access does not assert stall.
    MRead = 0; MWrite = 0;
    exp_stall = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    MRead = 0; MWrite = 0; WB = 0; RegWrite = 0;
    ALUIn = 0; WriteData = 0; RegRD = 0; mem_rdata = 0; mem_ack = 0;
    repeat (2) @(posedge clock);
    #1;
    zero_expect();
    chk_on = 1'b1;
    chk("reset_mem_req", mem_req, 1'b0);
    chk("reset_ReadDataReg", ReadDataReg, 32'h0);
    tick();
    rst = 1'b1;

    // Mixed stream: ALU op, zero-wait load with spurious IDLE acks, ALU op
    exec(0, 0, 0, 1, 32'd7, 32'h0, 5'd3, 0, 32'h0, 1, -1);
    chk("mix_alu_ALUreg", ALUreg, 32'd7);
    chk("mix_alu_RegRDreg", RegRDreg, 5'd3);
    chk("mix_alu_RegWritereg", RegWritereg, 1'b1);
    exec(1, 0, 1, 1, 32'h40, 32'h0, 5'd9, 0, 32'hCAFEF00D, 1, -1);
    chk("mix_load_rdata", ReadDataReg, 32'hCAFEF00D);
    exec(0, 0, 0, 1, 32'd11, 32'h0, 5'd4, 0, 32'h0, 1, -1);
    chk("mix_alu2_ALUreg", ALUreg, 32'd11);

    // Load with ack after 3 BUSY cycles
    stall_hi = 0;
    exec(1, 0, 1, 1, 32'h100, 32'h0, 5'd5, 3, 32'hDEADBEEF, 0, -1);
    chk("load_stall_cycles", stall_hi, 32'd4);
    chk("load_rdata", ReadDataReg, 32'hDEADBEEF);
    chk("load_RegRDreg", RegRDreg, 5'd5);
    chk("load_RegWritereg", RegWritereg, 1'b1);

    // Zero-wait store
    stall_hi = 0;
    exec(0, 1, 0, 0, 32'h200, 32'h12345678, 5'd0, 0, 32'h55555555, 0, -1);
    chk("store_stall_cycles", stall_hi, 32'd1);
    chk("store_rdata_held", ReadDataReg, 32'hDEADBEEF);

    // Misaligned load
    req_hi = 0; stall_hi = 0;
    exec(1, 0, 1, 1, 32'h103, 32'h0, 5'd6, 0, 32'h0, 0, -1);
    chk("mis_req_cycles", req_hi, 32'd0);
    chk("mis_stall_cycles", stall_hi, 32'd0);
    chk("mis_pulse", misalign_err, 1'b1);
    chk("mis_RegWritereg", RegWritereg, 1'b0);

    // Timeout
    req_hi = 0; stall_hi = 0;
    exec(1, 0, 1, 1, 32'h300, 32'h0, 5'd7, 99, 32'h0, 0, -1);
    chk("to_req_cycles", req_hi, 32'd4);
    chk("to_stall_cycles", stall_hi, 32'd4);
    chk("to_bus_err", bus_err, 1'b1);
    chk("to_RegWritereg", RegWritereg, 1'b0);

    // Reset mid-BUSY together with an ack
    exec(1, 0, 1, 1, 32'h400, 32'h0, 5'd8, 99, 32'hFFFFFFFF, 0, 1);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_ReadDataReg", ReadDataReg, 32'h0);

    // Randomized stream
    for (int n = 0; n < 400; n++) begin
      int   kind;
      bit   r, w;
      logic [31:0] a;
      int   ab;
      kind = $urandom_range(0, 9);
      r = (kind < 4) || (kind == 8);
      w = (kind >= 4 && kind < 7) || (kind == 8);
      a = $urandom;
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      ab = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, T - 1)) : -1;
      exec(r, w, 1'($urandom), 1'($urandom), a, $urandom, 5'($urandom),
           int'($urandom_range(0, T + 1)), $urandom, 1'($urandom), ab);
    end

    tick();
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
